// File: rtl/pipe_rca_adder.sv
// pipe_rca_adder: WIDTH-bit adder/subtractor built from STAGES registered ripple slices with
// valid/ready flow control. Define PIPE_RCA_OVF_EN to generate the registered signed-overflow flag.
module pipe_rca_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int unsigned S = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_cin0;

  assign w_bx     = Sub ? ~B : B;
  assign w_cin0   = Sub | Cin;
  assign w_adv    = out_ready || !out_valid;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [S-1:0]       w_a_sl;
    logic [S-1:0]       w_b_sl;
    logic [S-1:0]       w_sum_sl;
    logic               w_cin;
    logic               w_vin;
    logic               w_cout;
    logic [(k+1)*S-1:0] r_sum;
    logic               r_c;
    logic               r_v;

    if (k == 0) begin : g_src
      assign w_a_sl = A[S-1:0];
      assign w_b_sl = w_bx[S-1:0];
      assign w_cin  = w_cin0;
      assign w_vin  = in_valid;
    end else begin : g_src
      assign w_a_sl = g_stage[k-1].g_hi.r_a_hi[S-1:0];
      assign w_b_sl = g_stage[k-1].g_hi.r_b_hi[S-1:0];
      assign w_cin  = g_stage[k-1].r_c;
      assign w_vin  = g_stage[k-1].r_v;
    end

    assign {w_cout, w_sum_sl} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{S{1'b0}}, w_cin};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vin;
        r_c <= w_cout;
      end
    end

    // Finished lower slices ride along beside the new slice so the full sum lines up at the end.
    if (k == 0) begin : g_sum
      always_ff @(posedge clk) begin
        if (rst)        r_sum <= '0;
        else if (w_adv) r_sum <= w_sum_sl;
      end
    end else begin : g_sum
      always_ff @(posedge clk) begin
        if (rst)        r_sum <= '0;
        else if (w_adv) r_sum <= {w_sum_sl, g_stage[k-1].r_sum};
      end
    end

    if (k < STAGES - 1) begin : g_hi
      localparam int unsigned HI_W = WIDTH - (k + 1) * S;
      logic [HI_W-1:0] r_a_hi;
      logic [HI_W-1:0] r_b_hi;
      logic [HI_W-1:0] w_a_nx;
      logic [HI_W-1:0] w_b_nx;

      if (k == 0) begin : g_nx
        assign w_a_nx = A[WIDTH-1:S];
        assign w_b_nx = w_bx[WIDTH-1:S];
      end else begin : g_nx
        assign w_a_nx = g_stage[k-1].g_hi.r_a_hi[HI_W+S-1:S];
        assign w_b_nx = g_stage[k-1].g_hi.r_b_hi[HI_W+S-1:S];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_hi <= '0;
          r_b_hi <= '0;
        end else if (w_adv) begin
          r_a_hi <= w_a_nx;
          r_b_hi <= w_b_nx;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign Sum       = g_stage[STAGES-1].r_sum;
  assign Cout      = g_stage[STAGES-1].r_c;

`ifdef PIPE_RCA_OVF_EN
  logic r_ovf;
  logic w_ovf_nx;

  assign w_ovf_nx = (g_stage[STAGES-1].w_a_sl[S-1] == g_stage[STAGES-1].w_b_sl[S-1]) &&
                    (g_stage[STAGES-1].w_sum_sl[S-1] != g_stage[STAGES-1].w_a_sl[S-1]);

  always_ff @(posedge clk) begin
    if (rst)        r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= w_ovf_nx;
  end

  assign Ovf = r_ovf;
`else
  assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Testbench for pipe_rca_adder (WIDTH=16, STAGES=4): directed vectors, streaming, stall,
// reset flush and random traffic scored against an arithmetic reference queue.
module tb_pipe_rca_adder;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;
`ifdef PIPE_RCA_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout, Ovf;
  logic [15:0] A, B, Sum;

  pipe_rca_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    int unsigned ua, ub, r;
    int          sa, sb, sr;
    ua = 32'(a);
    ub = 32'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r      = ua - ub;
      e.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      r      = ua + ub + 32'(cin);
      e.cout = (r > 32'h0000_FFFF);
      sr     = sa + sb + int'(cin);
    end
    e.sum = r[15:0];
    e.ovf = OVF_EN && (sr > 32767 || sr < -32768);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: score any consumed result at negedge, record acceptance at posedge, return #1 after.
  task automatic cycle();
    bit   acc;
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (out_valid && out_ready && !rst) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h expected no beat", Sum);
      end else begin
        e = q.pop_front();
        check("sb_sum", 32'(Sum), 32'(e.sum));
        check("sb_cout", 32'(Cout), 32'(e.cout));
        check("sb_ovf", 32'(Ovf), 32'(e.ovf));
      end
    end
    @(posedge clk);
    if (rst)      q.delete();
    else if (acc) q.push_back(model(A, B, Cin, Sub));
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    check("vec_in_ready", 32'(in_ready), 32'd1);
    A = v.a; B = v.b; Cin = v.cin; Sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      cycle();
      lat++;
      seen = out_valid;
    end
    check("vec_latency", 32'(lat), 32'(STAGES - 1));
    check("vec_sum", 32'(Sum), 32'(v.sum));
    check("vec_cout", 32'(Cout), 32'(v.cout));
    check("vec_ovf", 32'(Ovf), 32'(v.ovf));
    cycle();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] got[$];
    int          idx[$];
    logic [15:0] snap_sum;
    logic        snap_cout;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_EN};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_EN};
    vecs[5] = '{16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Streaming: 8 back-to-back beats, results must come out consecutively.
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      A = 16'(c + 1);
      B = 16'(16'h0100 * (c + 1));
      Cin = 1'b0; Sub = 1'b0;
      cycle();
      if (out_valid) begin
        got.push_back(Sum);
        idx.push_back(c);
      end
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      check("stream_sum", 32'(got[k]), 32'(16'h0101 * (k + 1)));
      check("stream_gap", 32'(idx[k]), 32'(idx[0] + k));
    end
    check("stream_first_cycle", 32'(idx.size() > 0 ? idx[0] : -1), 32'(STAGES - 1));
    drain();

    // Backpressure: fill the pipe, then hold out_ready low for 3 cycles.
    in_valid = 1'b1;
    for (int c = 0; c < STAGES; c++) begin
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
      cycle();
    end
    check("bp_full_valid", 32'(out_valid), 32'd1);
    snap_sum = Sum;
    snap_cout = Cout;
    out_ready = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    #1;
    check("bp_in_ready_now", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_sum_hold", 32'(Sum), 32'(snap_sum));
      check("bp_cout_hold", 32'(Cout), 32'(snap_cout));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
      cycle();
    end
    drain();

    // Reset with 3 beats in flight: none of them may ever appear.
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_sum", 32'(Sum), 32'd0);
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("flush_stays_empty", 32'(out_valid), 32'd0);
    end
    run_vec(vecs[0]);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 9) < 7);
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
